// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its writer/reader masters.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PKT_LEN_DEF    = 16;
    localparam int CNT_W_DEF      = 16;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order holding buffer: entry0 is always the head, entry1 the
// second-oldest word. Pushes beyond two entries are dropped.
module stream_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = entry0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Head retires and the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master: pops the synchronous FIFO (1-cycle read latency) and
// presents words on a valid/ready stream with frame tagging and a beat count.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PKT_LEN    = PKT_LEN_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_W-1:0]      words_out
);

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(PKT_LEN - 1);

    logic [1:0]       buf_cnt;
    logic             inflight;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] words_cnt;
    logic [2:0]       occupancy;
    logic             handshake;

    // Stream contract: a beat moves on a rising edge where m_valid && m_ready;
    // while m_valid && !m_ready, m_data and m_last are held unchanged.
    assign m_valid   = (buf_cnt != 2'd0);
    assign handshake = m_valid && m_ready;
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};

    // Words already buffered plus the one in flight never exceed two slots.
    assign fifo_rd_en = !fifo_empty && !rst && ((occupancy < 3'd2) || handshake);

    assign m_last    = (beat_cnt == BEAT_LAST) && m_valid;
    assign words_out = words_cnt;

    stream_skid_buf #(
        .W (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (handshake),
        .head      (m_data),
        .count     (buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= 1'b0;
            beat_cnt  <= '0;
            words_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (handshake) begin
                words_cnt <= words_cnt + 1'b1;
                beat_cnt  <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed-then-random bench for fifo_stream_reader against a queue-based
// FIFO stand-in and an in-order delivery model.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int DW  = 8;
    localparam int P16 = 16;
    localparam int P4  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_ready = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;

    logic          fifo_rd_en, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic [15:0]   words_out;
    logic          fifo_rd_en4, m_valid4, m_last4;
    logic [DW-1:0] m_data4;
    logic [3:0]    words_out4;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int  checks = 0, errors = 0, pops = 0, hs_total = 0, n = 0;
    bit  last_pop = 1'b0, stall_prev = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(P16), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .words_out(words_out)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(P4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en4), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .m_last(m_last4), .words_out(words_out4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO stand-in: registered empty flag, data one cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_dout <= fifo_q[0];
            exp_q.push_back(fifo_q[0]);
            void'(fifo_q.pop_front());
            pops++;
        end
        last_pop = fifo_rd_en;
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Delivery model: every popped word comes out once, in pop order,
    // unless a reset drops everything popped but not yet delivered.
    always @(negedge clk) begin
        int bc;
        bit mv;
        if (rst) begin
            chk("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
            exp_q.delete();
            n = 0;
            stall_prev = 1'b0;
        end else begin
            bc = exp_q.size() - int'(last_pop);
            mv = (bc != 0);
            chk("issue_rule", {31'd0, fifo_rd_en},
                {31'd0, !fifo_empty && (exp_q.size() < 2 || (mv && m_ready))});
            chk("m_valid", {31'd0, m_valid}, {31'd0, mv});
            if (mv) chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
            chk("m_last16", {31'd0, m_last}, {31'd0, mv && (n % P16 == P16 - 1)});
            chk("m_last4", {31'd0, m_last4}, {31'd0, mv && (n % P4 == P4 - 1)});
            chk("words_out", {16'd0, words_out}, n % 65536);
            chk("words_out4", {28'd0, words_out4}, n % 16);
            chk("twin_rd_en", {31'd0, fifo_rd_en4}, {31'd0, fifo_rd_en});
            chk("twin_m_valid", {31'd0, m_valid4}, {31'd0, m_valid});
            chk("twin_m_data", {24'd0, m_data4}, {24'd0, m_data});
            if (stall_prev) begin
                chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            stall_prev = mv && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (mv && m_ready) begin
                void'(exp_q.pop_front());
                n++;
                hs_total++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready low, 1 ready high, 2 toggle, 3 random.
    task automatic run_window(input int cyc, input int rmode,
                              output int rd_n, output int rd_span,
                              output int hs_n, output int hs_span,
                              output int last16_n, output int last16_idx,
                              output logic [31:0] last4_mask);
        int first_rd, first_hs;
        rd_n = 0; hs_n = 0; last16_n = 0; last16_idx = -1; last4_mask = '0;
        first_rd = -1; first_hs = -1; rd_span = 0; hs_span = 0;
        for (int c = 0; c < cyc; c++) begin
            case (rmode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                2: m_ready = (c % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = c;
                rd_span = c - first_rd;
                rd_n++;
            end
            if (m_valid && m_ready) begin
                if (first_hs < 0) first_hs = c;
                hs_span = c - first_hs;
                if (m_last) begin
                    last16_n++;
                    if (last16_idx < 0) last16_idx = hs_n;
                end
                if (m_last4 && hs_n < 32) last4_mask[hs_n] = 1'b1;
                hs_n++;
            end
            step();
        end
    endtask

    initial begin
        int rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, rem, w, h0, k;
        logic [31:0] l4_mask;

        // Reset state.
        step(); step();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_words_out", {16'd0, words_out}, 32'd0);

        // Full rate: 0..15 preloaded, ready high.
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
        step();
        rst = 1'b0;
        run_window(30, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("full_rd_count", rd_n, 16);
        chk("full_rd_span", rd_span, 15);
        chk("full_hs_count", hs_n, 16);
        chk("full_hs_span", hs_span, 15);
        chk("full_last_count", l16_n, 1);
        chk("full_last_idx", l16_idx, 15);
        chk("full_words_out", {16'd0, words_out}, 32'd16);

        // Back-pressure with alternating ready.
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
        run_window(40, 2, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("bp_hs_count", hs_n, 8);
        chk("bp_rd_count", rd_n, 8);
        chk("bp_drained", {31'd0, m_valid}, 32'd0);

        // Stall while full: only two pops, then a gap-free release.
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(i));
        run_window(8, 0, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("stall_pops", rd_n, 2);
        chk("stall_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
        chk("stall_m_valid", {31'd0, m_valid}, 32'd1);
        run_window(15, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("release_hs_count", hs_n, 10);
        chk("release_hs_span", hs_span, 9);

        // Empty FIFO, then a single word.
        run_window(5, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("empty_rd", rd_n, 0);
        chk("empty_hs", hs_n, 0);
        m_ready = 1'b0;
        fifo_q.push_back(8'hA5);
        k = 0;
        while (!m_valid && k < 6) begin
            step();
            k++;
        end
        chk("single_latency", k, 3);
        chk("single_data", {24'd0, m_data}, 32'h0000_00A5);
        m_ready = 1'b1;
        step();

        // Framing on the PKT_LEN=4 twin: last on beats 3, 7, then 11.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'($urandom));
        run_window(20, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("frame_hs", hs_n, 10);
        chk("frame_last4_mask", l4_mask, 32'h0000_0088);
        for (int i = 0; i < 2; i++) fifo_q.push_back(DW'($urandom));
        run_window(8, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("frame_tail_mask", l4_mask, 32'h0000_0002);
        chk("frame_words_out4", {28'd0, words_out4}, 32'd12);

        // Reset mid-stream with a word in flight.
        for (int i = 0; i < 40; i++) fifo_q.push_back(DW'($urandom));
        run_window(6, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("pre_rst_streaming", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("post_rst_words_out", {16'd0, words_out}, 32'd0);
        chk("post_rst_m_last", {31'd0, m_last}, 32'd0);
        rem = fifo_q.size();
        run_window(60, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("post_rst_hs", hs_n, rem);
        chk("post_rst_last16_idx", l16_idx, 15);
        chk("post_rst_last4", {28'd0, l4_mask[3:0]}, 32'd8);

        // Random traffic and random back-pressure.
        w  = 0;
        h0 = hs_total;
        for (int c = 0; c < 400; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 12) begin
                fifo_q.push_back(DW'($urandom));
                w++;
            end
            step();
        end
        run_window(40, 1, rd_n, rd_span, hs_n, hs_span, l16_n, l16_idx, l4_mask);
        chk("random_delivered", hs_total - h0, w);
        chk("random_drained", {31'd0, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO (clk, wr_en/rd_en, din/dout, full/empty, 1-cycle read latency).
- Pops words from the FIFO and presents them on a valid/ready output stream, with a 2-entry output buffer so the stream sustains 1 word/cycle under back-pressure.
- Tags every PKT_LEN-th beat as last, for framing downstream consumers.
- Sits between the FIFO instance and any stream sink.

Parameters:
- DATA_WIDTH, 8: width of FIFO dout and m_data.
- PKT_LEN, 16: beats per frame; m_last asserted on beat PKT_LEN-1. Legal range 1..65535.
- CNT_W, 16: width of the beat counter and the words_out statistic. Must satisfy 2^CNT_W >= PKT_LEN.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- fifo_rd_en, out, 1: pop request to the FIFO rd_en.
- fifo_dout, in, DATA_WIDTH: FIFO read data, valid exactly 1 cycle after fifo_rd_en.
- fifo_empty, in, 1: FIFO empty flag.
- m_valid, out, 1: output word available.
- m_ready, in, 1: sink accepts the word.
- m_data, out, DATA_WIDTH: output word.
- m_last, out, 1: current beat is the final beat of a frame.
- words_out, out, CNT_W: total handshakes since reset; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, words_out=0.
  - Buffer count, in-flight flag and beat counter = 0.
- State:
  - buf_cnt in 0..2: 2-entry FIFO-ordered output buffer.
  - inflight: 1 bit; a read was issued last cycle.
  - beat counter: 0..PKT_LEN-1.
- Handshake: a beat transfers when m_valid && m_ready.
  - m_valid = (buf_cnt != 0).
  - m_data is the buffer head. m_data/m_last hold stable while m_valid && !m_ready.
- Issue rule (combinational): fifo_rd_en = !fifo_empty && !rst && ((buf_cnt + inflight) < 2 || (m_valid && m_ready)).
  - Guarantees buf_cnt + inflight <= 2 at all times; the buffer never overflows.
- Capture: inflight <= fifo_rd_en.
  - When inflight=1, fifo_dout is written into the buffer tail that cycle.
- Simultaneous capture and handshake: head retires, new word appends, buf_cnt unchanged.
  - With buf_cnt=1, the captured word becomes head on the next cycle.
- Latency: FIFO non-empty with the buffer empty -> fifo_rd_en same cycle -> m_valid on the 2nd rising edge after the edge that saw !fifo_empty. First word appears 2 cycles after pop issue at the latest.
- Throughput: with m_ready held high and the FIFO non-empty, one beat per cycle after fill.
- Framing and statistics on each handshake:
  - beat counter increments; it wraps to 0 after PKT_LEN-1.
  - m_last = (beat counter == PKT_LEN-1) && m_valid.
  - PKT_LEN=1: every beat is last.
  - words_out increments, wrapping at 2^CNT_W.
- Empty FIFO: no pop is issued. m_valid drops after the buffer drains; no bubble words.
- fifo_empty deasserting while inflight=1: a new pop is legal the same cycle if the issue rule allows.
- Reset mid-operation:
  - Buffer, inflight, beat counter and words_out are cleared.
  - A word arriving on fifo_dout the cycle after reset is discarded; that FIFO word is lost by design.
  - fifo_rd_en is forced 0 while rst=1.
- m_ready asserted while m_valid=0: ignored; no counter change.

Decomposition:
- Shared package fifo_pkg: DATA_WIDTH default, PKT_LEN default, and a typedef for the data word, shared with the FIFO and the writer side.
- One natural sub-module: stream_skid_buf, a 2-entry valid/ready buffer with push, pop and count.
- Top level holds the issue rule, inflight flag, beat counter and words_out.

Test Plan:
- Stream at full rate: reset, FIFO preloaded with 0..15, m_ready=1 -> fifo_rd_en high 16 consecutive cycles; m_data 0..15 on consecutive cycles; m_last only on data 15; words_out=16.
- Back-pressure: preload 0..7, m_ready toggles 1,0,1,0 -> order preserved, no duplicate/drop; fifo_rd_en never raises buf_cnt+inflight above 2; m_data stable while stalled.
- Stall while full: m_ready=0 with FIFO holding 10 words -> exactly 2 pops issued, then fifo_rd_en=0; releasing m_ready delivers 0,1,2,... with no gap.
- Empty FIFO: fifo_empty=1 throughout -> fifo_rd_en=0, m_valid=0; one word 0xA5 written -> m_valid with m_data=0xA5 within 2 cycles of empty dropping.
- Framing wrap: PKT_LEN=4, 10 beats -> m_last on beats 3 and 7; beat counter reads 2 at end.
- Reset mid-stream: rst for 1 cycle with inflight=1 and buf_cnt=2 -> m_valid=0, words_out=0 next cycle; the in-flight word is discarded; subsequent FIFO words stream correctly, m_last again at beat PKT_LEN-1.
